mem_sram_ctrl: RTL and testbench
================================

MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock `clk` and a synchronous, active-low reset `rst`; `rst` is sampled only on the rising edge of `clk`.
REQ-002 Parameter WAIT_CYCLES, default 1: number of cycles each SRAM strobe is held; legal range 1..15.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-low reset.
REQ-005 mem_ce_i  in  1  memory access request from the MEM stage.
REQ-006 mem_we_i  in  1  1 = store, 0 = load.
REQ-007 mem_addr_i  in  32  byte address; only bits [21:2] are used.
REQ-008 mem_sel_i  in  4  byte-lane enables, with bit 3 selecting byte 3.
REQ-009 mem_data_i  in  32  store data.
REQ-010 mem_data_o  out  32  load word returned to MEM; the full word, with no lane extraction.
REQ-011 stallreq_o  out  1  pipeline stall request (combinational).
REQ-012 sram_addr_o  out  20  SRAM word address.
REQ-013 sram_data_o  out  32  SRAM write data.
REQ-014 sram_data_i  in  32  SRAM read data.
REQ-015 sram_data_oe_o  out  1  1 = controller drives the SRAM data bus.
REQ-016 sram_ce_n_o / sram_oe_n_o / sram_we_n_o  out  1 each  active-low SRAM chip enable, output enable and write enable.
REQ-017 sram_be_n_o  out  4  active-low byte enables.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-019 IDLE with mem_ce_i=1: at the clock edge, latch addr[21:2], sel, data and we; clear the counter; go to ACCESS.
REQ-020 On entry to ACCESS: ce_n=0; be_n=~sel.
  - Load: oe_n=0, we_n=1, data_oe=0.
  - Store: oe_n=1, we_n=0, data_oe=1.
  - All strobes are registered outputs.
REQ-021 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter. At the edge ending the last ACCESS cycle:
  - load: capture sram_data_i into the read register;
  - ce_n, oe_n, we_n, be_n go back to 1s and data_oe to 0;
  - state goes to DONE.
REQ-022 DONE SHALL last one cycle, then go to IDLE.
  - mem_data_o holds the captured word from DONE until the next load capture.
REQ-023 stallreq_o SHALL be 1 in two cases: (IDLE and mem_ce_i=1), or state=ACCESS. It is 0 in DONE, and 0 while rst=0.
REQ-024 A load therefore stalls for 1+WAIT_CYCLES cycles; the pipeline advances at the edge that ends DONE.
REQ-025 mem_ce_i=0 in IDLE SHALL keep the FSM in IDLE with all strobes inactive.
REQ-026 mem_ce_i=1 in the IDLE cycle right after DONE SHALL be treated as a new access; there are no idle gap cycles between back-to-back accesses.
REQ-027 sram_addr_o and sram_data_o SHALL stay stable from ACCESS entry through the cycle after the strobes deassert.
REQ-028 Input changes during ACCESS or DONE SHALL be ignored.

Reset
REQ-029 rst=0 at a clock edge SHALL force the following, from any state, including in the middle of an access:
  - state = IDLE;
  - sram_ce_n_o = 1, sram_oe_n_o = 1, sram_we_n_o = 1, sram_be_n_o = 4'hF, sram_data_oe_o = 0;
  - sram_addr_o = 0, sram_data_o = 0, mem_data_o = 0, counter = 0.
REQ-030 An access interrupted by reset SHALL be dropped and is not retried.

Configuration
REQ-031 Macro SRAM_POSTED_STORE_EN SHALL select posted stores.
REQ-032 With SRAM_POSTED_STORE_EN defined:
  - A store in IDLE does not assert stallreq_o and is latched at that edge.
  - ACCESS for the store then goes directly to IDLE, skipping DONE.
  - Any mem_ce_i=1 while state is not IDLE asserts stallreq_o until the FSM is back in IDLE; the request is then handled per REQ-019.
REQ-033 Without the macro, stores behave exactly like loads in timing and stall behaviour (REQ-019..REQ-024).

Verification
REQ-034 Load, WAIT_CYCLES=2, addr 0x0000_0104, SRAM word 0xDEADBEEF:
  - stallreq_o = 1,1,1,0 over 4 cycles;
  - sram_addr_o = 0x00041 and oe_n = 0 for 2 cycles;
  - mem_data_o = 0xDEADBEEF in DONE.
REQ-035 Store, macro off, WAIT_CYCLES=1, addr 0x10, sel 4'b0011, data 0x12345678:
  - we_n low for 1 cycle, be_n = 4'b1100, sram_addr_o = 0x00004, data_oe = 1;
  - stallreq_o = 1,1,0.
REQ-036 Back-to-back load then store, WAIT_CYCLES=1: the second access enters ACCESS on the edge right after DONE, and the strobes of the two accesses never overlap.
REQ-037 rst=0 asserted during the second ACCESS cycle of a store (WAIT_CYCLES=3):
  - at the next edge, we_n = 1, be_n = 4'hF, data_oe = 0 and state = IDLE;
  - stallreq_o = 0 while rst = 0;
  - no further strobes follow.
REQ-038 Macro on, store (0x20, 0xCAFEF00D) followed next cycle by a load from 0x20, WAIT_CYCLES=2:
  - the store causes no stall;
  - the load stalls until the store completes, then for 3 more cycles;
  - mem_data_o = 0xCAFEF00D (SRAM model).
REQ-039 mem_ce_i held at 0 for 10 cycles: all strobes inactive, stallreq_o = 0 and mem_data_o unchanged throughout.

Source files
------------

// File: rtl/mem_sram_ctrl_if.sv
// rtl/mem_sram_ctrl_if.sv - MEM-stage and asynchronous SRAM signal bundle for mem_sram_ctrl
interface mem_sram_ctrl_if;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        stallreq_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_data_o;
    logic [31:0] sram_data_i;
    logic        sram_data_oe_o;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic [3:0]  sram_be_n_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, sram_data_i,
        input  mem_data_o, stallreq_o, sram_addr_o, sram_data_o, sram_data_oe_o,
        input  sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, sram_data_i,
        output mem_data_o, stallreq_o, sram_addr_o, sram_data_o, sram_data_oe_o,
        output sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// rtl/mem_sram_ctrl.sv - MEM-stage to async SRAM controller; define SRAM_POSTED_STORE_EN for posted stores
module mem_sram_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input logic           clk,
    input logic           rst,
    mem_sram_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

`ifdef SRAM_POSTED_STORE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       we_q;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^{bus.mem_addr_i[31:22], bus.mem_addr_i[1:0]};

    // A posted store only holds the pipeline if another request arrives while it is in flight.
    assign bus.stallreq_o = rst &&
        (((state == IDLE) && bus.mem_ce_i && !(POSTED && bus.mem_we_i)) ||
         ((state == ACCESS) && (!(POSTED && we_q) || bus.mem_ce_i)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= IDLE;
            cnt                <= '0;
            we_q               <= 1'b0;
            bus.sram_addr_o    <= '0;
            bus.sram_data_o    <= '0;
            bus.mem_data_o     <= '0;
            bus.sram_ce_n_o    <= 1'b1;
            bus.sram_oe_n_o    <= 1'b1;
            bus.sram_we_n_o    <= 1'b1;
            bus.sram_be_n_o    <= 4'hF;
            bus.sram_data_oe_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_ce_i) begin
                        cnt                <= '0;
                        we_q               <= bus.mem_we_i;
                        bus.sram_addr_o    <= bus.mem_addr_i[21:2];
                        bus.sram_data_o    <= bus.mem_data_i;
                        bus.sram_ce_n_o    <= 1'b0;
                        bus.sram_oe_n_o    <= bus.mem_we_i;
                        bus.sram_we_n_o    <= !bus.mem_we_i;
                        bus.sram_be_n_o    <= ~bus.mem_sel_i;
                        bus.sram_data_oe_o <= bus.mem_we_i;
                        state              <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        if (!we_q) begin
                            bus.mem_data_o <= bus.sram_data_i;
                        end
                        // Address and write data stay put so the SRAM sees a clean hold time.
                        bus.sram_ce_n_o    <= 1'b1;
                        bus.sram_oe_n_o    <= 1'b1;
                        bus.sram_we_n_o    <= 1'b1;
                        bus.sram_be_n_o    <= 4'hF;
                        bus.sram_data_oe_o <= 1'b0;
                        state              <= (POSTED && we_q) ? IDLE : DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb/tb_mem_sram_ctrl.sv - self-checking bench for mem_sram_ctrl at WAIT_CYCLES 1, 2 and 3
module tb_mem_sram_ctrl;
`ifdef SRAM_POSTED_STORE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_sram_ctrl_if b0();
    mem_sram_ctrl_if b1();
    mem_sram_ctrl_if b3();

    mem_sram_ctrl #(.WAIT_CYCLES(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    mem_sram_ctrl #(.WAIT_CYCLES(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_sram_ctrl #(.WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];

    assign b0.sram_data_i = (!b0.sram_ce_n_o && !b0.sram_oe_n_o) ? mem0[b0.sram_addr_o[9:0]] : 32'h0;
    assign b1.sram_data_i = (!b1.sram_ce_n_o && !b1.sram_oe_n_o) ? mem1[b1.sram_addr_o[9:0]] : 32'h0;
    assign b3.sram_data_i = 32'h0;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 1024; i++) begin
                mem0[i] <= 32'h0;
                mem1[i] <= 32'h0;
            end
            mem0[4]     <= 32'h5A5A_1234;
            mem1[10'h41] <= 32'hDEAD_BEEF;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!b0.sram_ce_n_o && !b0.sram_we_n_o && !b0.sram_be_n_o[k])
                    mem0[b0.sram_addr_o[9:0]][k*8 +: 8] <= b0.sram_data_o[k*8 +: 8];
                if (!b1.sram_ce_n_o && !b1.sram_we_n_o && !b1.sram_be_n_o[k])
                    mem1[b1.sram_addr_o[9:0]][k*8 +: 8] <= b1.sram_data_o[k*8 +: 8];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] sb [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge once the pipeline advanced.
    task automatic acc1(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] data, input logic [31:0] rdata,
                        input int exp_n, input int exp_strobes);
        int n;
        int ns;
        logic [31:0] e;
        b1.mem_ce_i   = 1'b1;
        b1.mem_we_i   = we;
        b1.mem_addr_i = addr;
        b1.mem_sel_i  = sel;
        b1.mem_data_i = data;
        if (!we) sb.push_back(rdata);
        n  = 0;
        ns = 0;
        #1;
        while (b1.stallreq_o && n < 40) begin
            @(negedge clk);
            #1;
            n++;
            if (!b1.sram_ce_n_o && b1.sram_addr_o == addr[21:2] && b1.sram_be_n_o == ~sel &&
                b1.sram_oe_n_o == we && b1.sram_we_n_o == !we && b1.sram_data_oe_o == we &&
                (!we || b1.sram_data_o == data))
                ns++;
        end
        chk("stall_cycles", 64'(n), 64'(exp_n));
        if (exp_strobes >= 0) chk("strobe_cycles", 64'(ns), 64'(exp_strobes));
        if (!we) begin
            e = sb.pop_front();
            chk("load_data", 64'(b1.mem_data_o), 64'(e));
        end
        @(negedge clk);
    endtask

    task automatic chk0(input string nm, input logic stall, input logic [7:0] strb, input logic [19:0] addr);
        chk({nm, "_stall"}, 64'(b0.stallreq_o), 64'(stall));
        chk({nm, "_strobes"}, 64'({b0.sram_ce_n_o, b0.sram_oe_n_o, b0.sram_we_n_o,
                                   b0.sram_be_n_o, b0.sram_data_oe_o}), 64'(strb));
        chk({nm, "_addr"}, 64'(b0.sram_addr_o), 64'(addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0200, 4'hF,    32'hA5A5_5A5A, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0200, 4'hF,    32'h0,         32'hA5A5_5A5A};
        vecs[2] = '{1'b1, 32'h0000_0200, 4'b0011, 32'h1234_5678, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0200, 4'hF,    32'h0,         32'hA5A5_5678};
        vecs[4] = '{1'b1, 32'h003F_FFFC, 4'hF,    32'hFFFF_0001, 32'h0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 4'hF,    32'h0,         32'hFFFF_0001};
        vecs[6] = '{1'b1, 32'h0000_0204, 4'b1000, 32'h9988_7766, 32'h0};
        vecs[7] = '{1'b0, 32'h0000_0204, 4'hF,    32'h0,         32'h9900_0000};
        vecs[8] = '{1'b0, 32'h0000_0104, 4'hF,    32'h0,         32'hDEAD_BEEF};

        {b0.mem_ce_i, b0.mem_we_i, b0.mem_addr_i, b0.mem_sel_i, b0.mem_data_i} = '0;
        {b1.mem_ce_i, b1.mem_we_i, b1.mem_addr_i, b1.mem_sel_i, b1.mem_data_i} = '0;
        {b3.mem_ce_i, b3.mem_we_i, b3.mem_addr_i, b3.mem_sel_i, b3.mem_data_i} = '0;

        repeat (3) @(negedge clk);
        b1.mem_ce_i = 1'b1;
        #1;
        chk("rst_stall", 64'(b1.stallreq_o), 64'h0);
        chk("rst_strobes", 64'({b1.sram_ce_n_o, b1.sram_oe_n_o, b1.sram_we_n_o, b1.sram_be_n_o, b1.sram_data_oe_o}), 64'hFE);
        chk("rst_addr", 64'(b1.sram_addr_o), 64'h0);
        chk("rst_wdata", 64'(b1.sram_data_o), 64'h0);
        chk("rst_rdata", 64'(b1.mem_data_o), 64'h0);
        chk0("rst_u0", 1'b0, 8'hFE, 20'h0);
        b1.mem_ce_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            acc1(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, vecs[i].rdata,
                 (POSTED && vecs[i].we) ? 0 : 3, (POSTED && vecs[i].we) ? -1 : 2);
            if (POSTED && vecs[i].we) begin
                b1.mem_ce_i = 1'b0;
                repeat (3) @(negedge clk);
            end
        end

        // Store immediately followed by a load from the same word.
        acc1(1'b1, 32'h0000_0020, 4'hF, 32'hCAFE_F00D, 32'h0, POSTED ? 0 : 3, POSTED ? -1 : 2);
        acc1(1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'hCAFE_F00D, POSTED ? 5 : 3, 2);
        b1.mem_ce_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            b1.mem_addr_i = $urandom;
            b1.mem_we_i   = 1'($urandom);
            @(negedge clk);
            #1;
            chk("quiet_strobes", 64'({b1.sram_ce_n_o, b1.sram_oe_n_o, b1.sram_we_n_o, b1.sram_be_n_o, b1.sram_data_oe_o}), 64'hFE);
            chk("quiet_stall", 64'(b1.stallreq_o), 64'h0);
            chk("quiet_rdata", 64'(b1.mem_data_o), 64'hCAFE_F00D);
        end

        // Load then store back to back at WAIT_CYCLES=1.
        @(negedge clk);
        b0.mem_ce_i = 1'b1; b0.mem_we_i = 1'b0; b0.mem_addr_i = 32'h10; b0.mem_sel_i = 4'hF;
        #1 chk0("ld_idle", 1'b1, 8'hFE, 20'h0);
        @(negedge clk); #1 chk0("ld_access", 1'b1, 8'h20, 20'h4);
        @(negedge clk); #1 chk0("ld_done", 1'b0, 8'hFE, 20'h4);
        chk("ld_data", 64'(b0.mem_data_o), 64'h5A5A_1234);
        @(negedge clk);
        b0.mem_we_i = 1'b1; b0.mem_sel_i = 4'b0011; b0.mem_data_i = 32'h1234_5678;
        #1 chk0("st_idle", !POSTED, 8'hFE, 20'h4);
        @(negedge clk);
        b0.mem_ce_i = 1'b0;
        #1 chk0("st_access", !POSTED, 8'h59, 20'h4);
        chk("st_wdata", 64'(b0.sram_data_o), 64'h1234_5678);
        @(negedge clk); #1 chk0("st_after", 1'b0, 8'hFE, 20'h4);
        chk("st_wdata_hold", 64'(b0.sram_data_o), 64'h1234_5678);
        chk("st_rdata_hold", 64'(b0.mem_data_o), 64'h5A5A_1234);
        chk("st_sram_word", 64'(mem0[4]), 64'h5A5A_5678);

        // Reset during the second ACCESS cycle of a WAIT_CYCLES=3 store.
        @(negedge clk);
        b3.mem_ce_i = 1'b1; b3.mem_we_i = 1'b1; b3.mem_addr_i = 32'h40;
        b3.mem_sel_i = 4'hF; b3.mem_data_i = 32'h0000_0077;
        @(negedge clk);
        @(negedge clk);
        chk("mid_we_low", 64'(b3.sram_we_n_o), 64'h0);
        rst = 1'b0;
        #1 chk("mid_rst_stall", 64'(b3.stallreq_o), 64'h0);
        @(negedge clk); #1;
        chk("mid_rst_strobes", 64'({b3.sram_ce_n_o, b3.sram_oe_n_o, b3.sram_we_n_o, b3.sram_be_n_o, b3.sram_data_oe_o}), 64'hFE);
        chk("mid_rst_addr", 64'(b3.sram_addr_o), 64'h0);
        chk("mid_rst_wdata", 64'(b3.sram_data_o), 64'h0);
        chk("mid_rst_stall2", 64'(b3.stallreq_o), 64'h0);
        b3.mem_ce_i = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("post_rst_strobes", 64'({b3.sram_ce_n_o, b3.sram_oe_n_o, b3.sram_we_n_o, b3.sram_be_n_o, b3.sram_data_oe_o}), 64'hFE);
            chk("post_rst_stall", 64'(b3.stallreq_o), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
